// File: rtl/morse_pkg.sv
// Shared definitions for the Morse keyer: FSM state encoding, element and
// gap lengths in Morse units, the ROM code word layout and ASCII helpers.
package morse_pkg;

    typedef enum logic [2:0] {
        ST_IDLE     = 3'd0,
        ST_LOAD     = 3'd1,
        ST_MARK     = 3'd2,
        ST_GAP      = 3'd3,
        ST_CHAR_GAP = 3'd4,
        ST_WORD_GAP = 3'd5
    } morse_state_t;

    localparam int unsigned MAX_ELEMENTS         = 32'd5;
    localparam int unsigned DOT_UNITS            = 32'd1;
    localparam int unsigned DASH_UNITS           = 32'd3;
    localparam int unsigned GAP_UNITS            = 32'd1;
    localparam int unsigned CHAR_GAP_UNITS       = 32'd3;
    localparam int unsigned WORD_GAP_EXTRA_UNITS = 32'd4;
    localparam logic [7:0]  SPACE_CODE           = 8'h20;

    // valid=0 marks an unsupported character; len=0 with valid=1 is the space.
    // pat is left-aligned: pat[4] is the first element, 1 = dash.
    typedef struct packed {
        logic       valid;
        logic [2:0] len;
        logic [4:0] pat;
    } morse_code_t;

    // Lower-case letters share the upper-case codes.
    function automatic logic [7:0] fold_upper(input logic [7:0] c);
        if ((c >= 8'h61) && (c <= 8'h7A)) begin
            return c - 8'h20;
        end else begin
            return c;
        end
    endfunction

endpackage

// File: rtl/morse_rom.sv
// ASCII to Morse code lookup (purely combinational).
// Ports:
//   char_data : ASCII character (either case)
//   code      : {valid, len[2:0], pat[4:0]} for the folded character
module morse_rom
    import morse_pkg::*;
(
    input  logic [7:0]  char_data,
    output morse_code_t code
);

    logic [7:0] upper_s;

    // ITU code table indexed by the upper-case character.
    always_comb begin
        upper_s = fold_upper(char_data);
        code    = {1'b0, 3'd0, 5'b00000};
        case (upper_s)
            8'h41: code = {1'b1, 3'd2, 5'b01000}; // A .-
            8'h42: code = {1'b1, 3'd4, 5'b10000}; // B -...
            8'h43: code = {1'b1, 3'd4, 5'b10100}; // C -.-.
            8'h44: code = {1'b1, 3'd3, 5'b10000}; // D -..
            8'h45: code = {1'b1, 3'd1, 5'b00000}; // E .
            8'h46: code = {1'b1, 3'd4, 5'b00100}; // F ..-.
            8'h47: code = {1'b1, 3'd3, 5'b11000}; // G --.
            8'h48: code = {1'b1, 3'd4, 5'b00000}; // H ....
            8'h49: code = {1'b1, 3'd2, 5'b00000}; // I ..
            8'h4A: code = {1'b1, 3'd4, 5'b01110}; // J .---
            8'h4B: code = {1'b1, 3'd3, 5'b10100}; // K -.-
            8'h4C: code = {1'b1, 3'd4, 5'b01000}; // L .-..
            8'h4D: code = {1'b1, 3'd2, 5'b11000}; // M --
            8'h4E: code = {1'b1, 3'd2, 5'b10000}; // N -.
            8'h4F: code = {1'b1, 3'd3, 5'b11100}; // O ---
            8'h50: code = {1'b1, 3'd4, 5'b01100}; // P .--.
            8'h51: code = {1'b1, 3'd4, 5'b11010}; // Q --.-
            8'h52: code = {1'b1, 3'd3, 5'b01000}; // R .-.
            8'h53: code = {1'b1, 3'd3, 5'b00000}; // S ...
            8'h54: code = {1'b1, 3'd1, 5'b10000}; // T -
            8'h55: code = {1'b1, 3'd3, 5'b00100}; // U ..-
            8'h56: code = {1'b1, 3'd4, 5'b00010}; // V ...-
            8'h57: code = {1'b1, 3'd3, 5'b01100}; // W .--
            8'h58: code = {1'b1, 3'd4, 5'b10010}; // X -..-
            8'h59: code = {1'b1, 3'd4, 5'b10110}; // Y -.--
            8'h5A: code = {1'b1, 3'd4, 5'b11000}; // Z --..
            8'h30: code = {1'b1, 3'd5, 5'b11111}; // 0
            8'h31: code = {1'b1, 3'd5, 5'b01111}; // 1
            8'h32: code = {1'b1, 3'd5, 5'b00111}; // 2
            8'h33: code = {1'b1, 3'd5, 5'b00011}; // 3
            8'h34: code = {1'b1, 3'd5, 5'b00001}; // 4
            8'h35: code = {1'b1, 3'd5, 5'b00000}; // 5
            8'h36: code = {1'b1, 3'd5, 5'b10000}; // 6
            8'h37: code = {1'b1, 3'd5, 5'b11000}; // 7
            8'h38: code = {1'b1, 3'd5, 5'b11100}; // 8
            8'h39: code = {1'b1, 3'd5, 5'b11110}; // 9
            SPACE_CODE: code = {1'b1, 3'd0, 5'b00000};
            default: code = {1'b0, 3'd0, 5'b00000};
        endcase
    end

endmodule

// File: rtl/morse_keyer.sv
// Morse keyer: accepts ASCII characters over a valid/ready handshake and
// produces the on/off keying stream, one Morse unit = TICK_RATE clocks.
// Ports:
//   CLK, RST_N  : clock, asynchronous active-low reset
//   CHAR_VALID  : upstream has a character on CHAR_DATA
//   CHAR_DATA   : ASCII character
//   CHAR_READY  : keyer is idle and takes CHAR_DATA this cycle
//   KEY         : keying output, 1 = mark
//   BUSY        : character or gap in progress
//   CHAR_START  : one-cycle pulse on the cycle after acceptance
module morse_keyer
    import morse_pkg::*;
#(
    parameter int unsigned TICK_RATE = 32'd2500000
) (
    input  logic       CLK,
    input  logic       RST_N,
    input  logic       CHAR_VALID,
    input  logic [7:0] CHAR_DATA,
    output logic       CHAR_READY,
    output logic       KEY,
    output logic       BUSY,
    output logic       CHAR_START
);

    localparam int unsigned CW = $clog2(64'(TICK_RATE) + 64'd1);
    localparam logic [CW-1:0] UNIT_LAST = CW'(TICK_RATE - 32'd1);
    // A space ends 2 clocks short of 4 units: the idle handshake cycle before
    // it and the one before the next character complete the word gap, so
    // mark-to-mark spacing in a held stream is exactly 7 units.
    localparam longint unsigned WG_END_POS =
        64'(WORD_GAP_EXTRA_UNITS) * 64'(TICK_RATE) - 64'd3;
    localparam logic [2:0]    WG_END_IDX = 3'(WG_END_POS / 64'(TICK_RATE));
    localparam logic [CW-1:0] WG_END_CNT = CW'(WG_END_POS % 64'(TICK_RATE));

    morse_state_t  state_r, state_nx_s;
    logic [CW-1:0] unit_cnt_r;
    logic [2:0]    unit_idx_r;
    logic [2:0]    elem_idx_r;
    morse_code_t   code_r;
    morse_code_t   rom_code_s;

    logic       transfer_s, unit_end_s, elem_end_s, last_elem_s;
    logic       gap_end_s, cgap_end_s, wgap_end_s, phase_end_s, is_letter_s;
    logic [2:0] elem_units_s;
    logic       key_nx_s, busy_nx_s, ready_nx_s, start_nx_s;

    morse_rom u_rom (
        .char_data (CHAR_DATA),
        .code      (rom_code_s)
    );

    // Element/gap timing decode from the counters.
    always_comb begin
        transfer_s   = CHAR_READY && CHAR_VALID;
        is_letter_s  = code_r.valid && (code_r.len != 3'd0);
        unit_end_s   = (unit_cnt_r == UNIT_LAST);
        elem_units_s = code_r.pat[3'd4 - elem_idx_r] ? 3'(DASH_UNITS) : 3'(DOT_UNITS);
        elem_end_s   = unit_end_s && (unit_idx_r == (elem_units_s - 3'd1));
        last_elem_s  = (elem_idx_r == (code_r.len - 3'd1));
        gap_end_s    = unit_end_s && (unit_idx_r == 3'(GAP_UNITS - 32'd1));
        cgap_end_s   = unit_end_s && (unit_idx_r == 3'(CHAR_GAP_UNITS - 32'd1));
        wgap_end_s   = (unit_idx_r == WG_END_IDX) && (unit_cnt_r == WG_END_CNT);
        // LOAD is the first clock of the first mark, so it ends elements too.
        phase_end_s  = (((state_r == ST_LOAD) && is_letter_s) || (state_r == ST_MARK))
                       ? elem_end_s : ((state_r == ST_GAP) && gap_end_s);
    end

    // State register.
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_nx_s;
        end
    end

    // Next-state logic.
    always_comb begin
        state_nx_s = state_r;
        case (state_r)
            ST_IDLE: begin
                state_nx_s = transfer_s ? ST_LOAD : ST_IDLE;
            end
            ST_LOAD: begin
                if (!code_r.valid) begin
                    state_nx_s = ST_IDLE;
                end else if (code_r.len == 3'd0) begin
                    state_nx_s = ST_WORD_GAP;
                end else if (elem_end_s) begin
                    // only reachable when a unit is a single clock
                    state_nx_s = last_elem_s ? ST_CHAR_GAP : ST_GAP;
                end else begin
                    state_nx_s = ST_MARK;
                end
            end
            ST_MARK: begin
                if (elem_end_s) begin
                    state_nx_s = last_elem_s ? ST_CHAR_GAP : ST_GAP;
                end else begin
                    state_nx_s = ST_MARK;
                end
            end
            ST_GAP:      state_nx_s = gap_end_s  ? ST_MARK : ST_GAP;
            ST_CHAR_GAP: state_nx_s = cgap_end_s ? ST_IDLE : ST_CHAR_GAP;
            ST_WORD_GAP: state_nx_s = wgap_end_s ? ST_IDLE : ST_WORD_GAP;
            default:     state_nx_s = ST_IDLE;
        endcase
    end

    // Output decode from the next state, registered below.
    always_comb begin
        key_nx_s   = (state_nx_s == ST_MARK) ||
                     ((state_nx_s == ST_LOAD) && rom_code_s.valid && (rom_code_s.len != 3'd0));
        busy_nx_s  = (state_nx_s != ST_IDLE);
        ready_nx_s = (state_nx_s == ST_IDLE);
        start_nx_s = (state_r == ST_IDLE) && (state_nx_s == ST_LOAD);
    end

    // Output registers.
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            KEY        <= 1'b0;
            BUSY       <= 1'b0;
            CHAR_READY <= 1'b1;
            CHAR_START <= 1'b0;
        end else begin
            KEY        <= key_nx_s;
            BUSY       <= busy_nx_s;
            CHAR_READY <= ready_nx_s;
            CHAR_START <= start_nx_s;
        end
    end

    // Unit, unit-index and element counters; all held at zero while idle.
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            unit_cnt_r <= '0;
            unit_idx_r <= 3'd0;
            elem_idx_r <= 3'd0;
        end else if (state_nx_s == ST_IDLE) begin
            unit_cnt_r <= '0;
            unit_idx_r <= 3'd0;
            elem_idx_r <= 3'd0;
        end else if (state_r != ST_IDLE) begin
            unit_cnt_r <= unit_end_s ? '0 : (unit_cnt_r + CW'(1));
            if (phase_end_s) begin
                unit_idx_r <= 3'd0;
            end else if (unit_end_s) begin
                unit_idx_r <= unit_idx_r + 3'd1;
            end else begin
                unit_idx_r <= unit_idx_r;
            end
            if ((state_r == ST_GAP) && gap_end_s) begin
                elem_idx_r <= elem_idx_r + 3'd1;
            end else begin
                elem_idx_r <= elem_idx_r;
            end
        end else begin
            unit_cnt_r <= '0;
            unit_idx_r <= 3'd0;
            elem_idx_r <= 3'd0;
        end
    end

    // Character code captured on acceptance.
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            code_r <= {1'b0, 3'd0, 5'b00000};
        end else if (transfer_s) begin
            code_r <= rom_code_s;
        end else begin
            code_r <= code_r;
        end
    end

endmodule

// File: tb/tb_morse_keyer.sv
module tb_morse_keyer;

    localparam int unsigned T = 4;

    logic       CLK = 1'b0;
    logic       RST_N = 1'b1;
    logic       CHAR_VALID = 1'b0;
    logic [7:0] CHAR_DATA = 8'h00;
    logic       CHAR_READY, KEY, BUSY, CHAR_START;

    always #5 CLK = ~CLK;

    morse_keyer #(.TICK_RATE(T)) dut (
        .CLK        (CLK),
        .RST_N      (RST_N),
        .CHAR_VALID (CHAR_VALID),
        .CHAR_DATA  (CHAR_DATA),
        .CHAR_READY (CHAR_READY),
        .KEY        (KEY),
        .BUSY       (BUSY),
        .CHAR_START (CHAR_START)
    );

    typedef struct packed { bit key; bit busy; bit ready; bit start; } exp_t;

    int   vectors = 0;
    int   miscompares = 0;
    int   accepts = 0;
    exp_t exp_q[$];
    bit   key_hist[$];
    bit   ready_hist[$];
    bit   start_hist[$];

    task automatic check(input string name, input logic act, input logic exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %b want %b at %0t", name, act, exp, $time);
        end
    endtask

    task automatic check_int(input string name, input int act, input int exp);
        vectors++;
        if (act != exp) begin
            miscompares++;
            $display("FAIL %s: got %0d want %0d at %0t", name, act, exp, $time);
        end
    endtask

    // ITU Morse text; "#" = unsupported.
    function automatic string morse_of(input byte c);
        byte u;
        u = (c >= "a" && c <= "z") ? byte'(c - 8'd32) : c;
        case (u)
            "A": return ".-";    "B": return "-...";  "C": return "-.-.";
            "D": return "-..";   "E": return ".";     "F": return "..-.";
            "G": return "--.";   "H": return "....";  "I": return "..";
            "J": return ".---";  "K": return "-.-";   "L": return ".-..";
            "M": return "--";    "N": return "-.";    "O": return "---";
            "P": return ".--.";  "Q": return "--.-";  "R": return ".-.";
            "S": return "...";   "T": return "-";     "U": return "..-";
            "V": return "...-";  "W": return ".--";   "X": return "-..-";
            "Y": return "-.--";  "Z": return "--..";
            "0": return "-----"; "1": return ".----"; "2": return "..---";
            "3": return "...--"; "4": return "....-"; "5": return ".....";
            "6": return "-...."; "7": return "--..."; "8": return "---..";
            "9": return "----.";
            " ": return " ";
            default: return "#";
        endcase
    endfunction

    task automatic push_run(input bit k, input int n);
        for (int i = 0; i < n; i++) exp_q.push_back('{key: k, busy: 1'b1, ready: 1'b0, start: 1'b0});
    endtask

    // Expected per-cycle outputs following acceptance of character c.
    task automatic push_char(input byte c);
        string m;
        int    b;
        m = morse_of(c);
        b = exp_q.size();
        if (m == "#") begin
            push_run(1'b0, 1);
        end else if (m == " ") begin
            // 7 units mark-to-mark including both idle handshake cycles
            push_run(1'b0, 4 * T - 2);
        end else begin
            for (int i = 0; i < m.len(); i++) begin
                push_run(1'b1, (m[i] == "-") ? 3 * T : T);
                if (i != m.len() - 1) push_run(1'b0, T);
            end
            push_run(1'b0, 3 * T);
        end
        exp_q[b].start = 1'b1;
    endtask

    // Per-cycle comparison against the model; also predicts transfers.
    always @(negedge CLK) begin
        exp_t e;
        if (!RST_N) begin
            exp_q.delete();
        end else begin
            if (exp_q.size() > 0) e = exp_q.pop_front();
            else e = '{key: 1'b0, busy: 1'b0, ready: 1'b1, start: 1'b0};
            check("key", KEY, e.key);
            check("busy", BUSY, e.busy);
            check("ready", CHAR_READY, e.ready);
            check("char_start", CHAR_START, e.start);
            key_hist.push_back(KEY);
            ready_hist.push_back(CHAR_READY);
            start_hist.push_back(CHAR_START);
            if (e.ready && CHAR_VALID) begin
                push_char(CHAR_DATA);
                accepts++;
            end
        end
    end

    function automatic int count_key(input int b, input int from, input int to);
        int n = 0;
        for (int i = from; i <= to; i++) if (b + i < key_hist.size() && key_hist[b + i]) n++;
        return n;
    endfunction

    function automatic int count_start(input int b, input int from, input int to);
        int n = 0;
        for (int i = from; i <= to; i++) if (b + i < start_hist.size() && start_hist[b + i]) n++;
        return n;
    endfunction

    function automatic int first_ready(input int b, input int from);
        for (int i = from; b + i < ready_hist.size(); i++) if (ready_hist[b + i]) return i;
        return -1;
    endfunction

    function automatic int zero_run(input int b, input int from);
        int n = 0;
        for (int i = from; b + i < key_hist.size(); i++) begin
            if (key_hist[b + i]) return n;
            n++;
        end
        return n;
    endfunction

    task automatic wait_accept(input int prev);
        int n = 0;
        while (accepts == prev && n < 300) begin
            @(posedge CLK); #1;
            n++;
        end
        if (accepts == prev) check_int("accept_timeout", accepts, prev + 1);
    endtask

    // Present each character with CHAR_VALID held, switching data on acceptance.
    task automatic send_str(input string s);
        int prev;
        for (int i = 0; i < s.len(); i++) begin
            prev = accepts;
            CHAR_DATA = s[i];
            CHAR_VALID = 1'b1;
            wait_accept(prev);
        end
        CHAR_VALID = 1'b0;
    endtask

    task automatic drain();
        int n = 0;
        while (exp_q.size() != 0 && n < 600) begin
            @(posedge CLK); #1;
            n++;
        end
        if (exp_q.size() != 0) check_int("drain_timeout", exp_q.size(), 0);
        repeat (2) @(posedge CLK);
        #1;
    endtask

    initial begin
        int b;
        int n;
        #3 RST_N = 1'b0;
        #1;
        check("rst_key", KEY, 1'b0);
        check("rst_busy", BUSY, 1'b0);
        check("rst_start", CHAR_START, 1'b0);
        repeat (3) @(posedge CLK);
        #1 RST_N = 1'b1;
        repeat (2) @(posedge CLK);
        #1;
        check("rst_ready", CHAR_READY, 1'b1);

        // 'E': mark cycles 1-4, ready again at cycle 17
        b = key_hist.size();
        send_str("E");
        drain();
        check_int("E_marks", count_key(b, 1, 20), 4);
        check_int("E_first_mark", key_hist[b + 1], 1);
        check_int("E_mark_end", key_hist[b + 5], 0);
        check_int("E_ready_cycle", first_ready(b, 1), 17);

        // 'a' folds to 'A': 16 mark cycles in 32
        b = key_hist.size();
        send_str("a");
        drain();
        check_int("a_marks", count_key(b, 1, 32), 16);
        check_int("a_ready_cycle", first_ready(b, 1), 33);
        send_str("A");
        drain();

        // "E E" streamed: 28 quiet cycles between marks
        b = key_hist.size();
        send_str("E E");
        drain();
        check_int("EsE_word_gap", zero_run(b, 5), 28);
        check_int("EsE_starts", count_start(b, 1, 40), 3);

        // unsupported '#'
        b = key_hist.size();
        send_str("#");
        drain();
        check_int("hash_marks", count_key(b, 1, 6), 0);
        check_int("hash_starts", count_start(b, 1, 6), 1);
        check_int("hash_ready_cycle", first_ready(b, 1), 2);

        // '0' interrupted by reset during the 3rd dash (cycles 33-44)
        b = key_hist.size();
        send_str("0");
        n = 0;
        while (key_hist.size() <= b + 38 && n < 100) begin
            @(posedge CLK); #1;
            n++;
        end
        check_int("zero_dash3", key_hist[b + 38], 1);
        #2 RST_N = 1'b0;
        #1;
        check("async_key", KEY, 1'b0);
        check("async_busy", BUSY, 1'b0);
        repeat (2) @(posedge CLK);
        #1 RST_N = 1'b1;
        @(posedge CLK); #1;
        check("post_rst_ready", CHAR_READY, 1'b1);
        b = key_hist.size();
        send_str("T");
        drain();
        check_int("T_marks", count_key(b, 1, 12), 12);
        check_int("T_tail", count_key(b, 13, 24), 0);

        // held-valid streams: one transfer per character
        b = key_hist.size();
        send_str("KM");
        drain();
        check_int("KM_starts", count_start(b, 1, key_hist.size() - b - 1), 2);
        send_str("SOS 19z");
        drain();

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, %0d miscompares", miscompares);
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/morse_keyer.md
MORSE_KEYER -- requirements
Module: morse_keyer

Interface
REQ-001 Parameter TICK_RATE, default 2500000, clocks per Morse unit; legal range 1 to 2^32-1.
REQ-002 CLK  input  1  system clock, 16 MHz; all state changes on its rising edge.
REQ-003 RST_N  input  1  asynchronous, active-low reset.
REQ-004 CHAR_VALID  input  1  upstream asserts while CHAR_DATA holds a character to send.
REQ-005 CHAR_DATA  input  8  ASCII character; held stable while CHAR_VALID=1.
REQ-006 CHAR_READY  output  1  keyer can accept a character this cycle.
REQ-007 KEY  output  1  on/off keying stream for the downstream LED/pin driver; 1 = mark.
REQ-008 BUSY  output  1  character or gap in progress.
REQ-009 CHAR_START  output  1  one-cycle pulse on the cycle after a character is accepted.

Function
REQ-010 Transfer occurs on a rising CLK edge with CHAR_VALID=1 and CHAR_READY=1; no other edge consumes a character.
REQ-011 CHAR_READY=1 only in state IDLE; it is never combinationally dependent on CHAR_VALID.
REQ-012 Supported set: 'A'-'Z', 'a'-'z' (folded to upper case), '0'-'9', and space (0x20), using ITU Morse codes.
REQ-013 Unsupported code: consumed, no KEY activity, CHAR_START still pulses, CHAR_READY=1 again on the second cycle after acceptance.
REQ-014 Timing unit = TICK_RATE clocks; unit counter clears on acceptance so unit boundaries align to the acceptance edge.
REQ-015 Dot = 1 unit KEY=1; dash = 3 units KEY=1; intra-character gap = 1 unit KEY=0.
REQ-016 After the last element, 3 units KEY=0 (character gap) before returning to IDLE.
REQ-017 Space: 4 units KEY=0 (7 total after a preceding character's gap), then IDLE.
REQ-018 Latency: KEY reflects the first element on the first cycle after acceptance.
REQ-019 FSM states: IDLE, LOAD, MARK, GAP, CHAR_GAP, WORD_GAP.
REQ-020 Transitions: IDLE->LOAD on transfer; LOAD->MARK (letter/digit), ->WORD_GAP (space), ->IDLE (unsupported); MARK->GAP when element ends and elements remain, else ->CHAR_GAP; GAP->MARK after 1 unit; CHAR_GAP and WORD_GAP->IDLE on completion.
REQ-021 LOAD lasts exactly one cycle and its duration is absorbed into the first unit, so element lengths are exact multiples of TICK_RATE.
REQ-022 BUSY=1 in every state except IDLE; KEY=1 only in MARK.
REQ-023 Element counter is 3 bits (max 5 elements); unit counter is $clog2(TICK_RATE+1) bits and never wraps past TICK_RATE-1.
REQ-024 Back-to-back: a character presented during a gap waits; it is accepted on the first IDLE cycle, so no gap between characters is shortened.

Reset
REQ-025 RST_N=0 forces IDLE asynchronously: KEY=0, BUSY=0, CHAR_START=0, CHAR_READY=1 after deassertion, all counters zero.
REQ-026 Reset mid-character abandons it; KEY drops to 0 without waiting for a clock edge.
REQ-027 RST_N deassertion is synchronous to CLK by the top-level reset synchronizer; the keyer adds none.

Structure
REQ-028 Package morse_pkg holds the state encoding, MAX_ELEMENTS=5, unit counts (DOT=1, DASH=3, GAP=1, CHAR_GAP=3, WORD_GAP_EXTRA=4) and the space code 0x20.
REQ-029 Sub-module morse_rom: combinational ASCII -> {valid, length[2:0], pattern[4:0]} (1=dash, MSB first), instanced once.

Verification (TICK_RATE=4)
REQ-030 'E' accepted at cycle 0 -> KEY=1 cycles 1-4, KEY=0 cycles 5-16, CHAR_READY=1 at cycle 17.
REQ-031 'a' -> KEY pattern 1,0,111,000 units = 32 cycles total, identical to 'A'.
REQ-032 "E E" streamed with CHAR_VALID held -> KEY=0 for exactly 28 cycles (7 units) between the two marks.
REQ-033 '#' -> no KEY pulse, CHAR_START pulses once, CHAR_READY=1 two cycles after acceptance.
REQ-034 '0' (5 dashes) with RST_N=0 during the 3rd dash -> KEY=0 immediately, BUSY=0, next 'T' after reset keys 3 units cleanly.
REQ-035 CHAR_VALID held with CHAR_READY=0 throughout a character -> CHAR_DATA not consumed until IDLE, exactly one transfer per character.
